// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - read-priority arbiter for the frame BRAM port A
// Reads win unless a pending write has been refused STARVE_MAX cycles in a row.
module vga_mem_arbiter #(
  parameter int MEM_WIDTH      = 8,
  parameter int MEM_DEPTH      = 38400,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int RD_LATENCY     = 1,
  parameter int STARVE_MAX     = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rd_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                      rd_ack_o,
  output logic                      rd_valid_o,
  output logic [MEM_WIDTH-1:0]      rd_data_o,
  input  logic                      wr_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [MEM_WIDTH-1:0]      wr_data_i,
  output logic                      wr_ack_o,
  output logic                      addr_err_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_WIDTH-1:0]      mem_din_o,
  input  logic [MEM_WIDTH-1:0]      mem_dout_i
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [MEM_ADDR_WIDTH:0] DEPTH = (MEM_ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [SW-1:0]       starve_ctr;
  logic                starved;
  logic                rd_grant;
  logic                wr_grant;
  logic                rd_oor;
  logic                wr_oor;
  logic [RD_LATENCY:0] vld_pipe;
  logic [RD_LATENCY:0] zero_pipe;

  assign starved  = wr_req_i && (starve_ctr == STARVE_TOP);
  assign wr_grant = wr_req_i && (starved || !rd_req_i);
  assign rd_grant = rd_req_i && !starved;
  assign rd_ack_o = rd_grant;
  assign wr_ack_o = wr_grant;

  assign rd_oor = {1'b0, rd_addr_i} >= DEPTH;
  assign wr_oor = {1'b0, wr_addr_i} >= DEPTH;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_ctr <= '0;
      vld_pipe   <= '0;
      zero_pipe  <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      addr_err_o <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_din_o  <= '0;
    end else begin
      if (!wr_req_i || wr_grant)
        starve_ctr <= '0;
      else if (starve_ctr != STARVE_TOP)
        starve_ctr <= starve_ctr + SW'(1);

      mem_en_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      addr_err_o <= 1'b0;
      if (rd_grant) begin
        addr_err_o <= rd_oor;
        mem_en_o   <= !rd_oor;
        if (!rd_oor)
          mem_addr_o <= rd_addr_i;
      end else if (wr_grant) begin
        addr_err_o <= wr_oor;
        if (!wr_oor) begin
          mem_en_o   <= 1'b1;
          mem_we_o   <= 1'b1;
          mem_addr_o <= wr_addr_i;
          mem_din_o  <= wr_data_i;
        end
      end

      // Out-of-range reads still occupy a pipeline slot so responses stay in order.
      vld_pipe   <= {vld_pipe[RD_LATENCY-1:0], rd_grant};
      zero_pipe  <= {zero_pipe[RD_LATENCY-1:0], rd_grant && rd_oor};
      rd_valid_o <= vld_pipe[RD_LATENCY];
      if (vld_pipe[RD_LATENCY])
        rd_data_o <= zero_pipe[RD_LATENCY] ? '0 : mem_dout_i;
    end
  end

endmodule
